// File: rtl/pcm_track_player.sv
// rtl/pcm_track_player.sv - frame-rate PCM clip sequencer between sample ROM and DAC serialiser
// Optional VOLUME_ATTEN_EN adds a 4-bit arithmetic-shift attenuation port `vol`.
module pcm_track_player #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int NUM_TRACKS = 4,
  parameter int TRK_W      = 2,
  parameter logic [NUM_TRACKS*ADDR_W-1:0] START_ADDRS = {4{18'd0}},
  parameter logic [NUM_TRACKS*ADDR_W-1:0] END_ADDRS   = {4{18'd200000}}
) (
  input  logic              DAC_LR_CLK,
  input  logic              reset,
  input  logic              play_req,
  input  logic [TRK_W-1:0]  track_sel,
  input  logic              loop_mode,
  input  logic              pause,
  input  logic              stop_req,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rden,
  input  logic [DATA_W-1:0] rom_q,
`ifdef VOLUME_ATTEN_EN
  input  logic [3:0]        vol,
`endif
  output logic [DATA_W-1:0] sample_out,
  output logic              busy,
  output logic [TRK_W-1:0]  cur_track,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_PLAY, S_PAUSE, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic              loop_q, loop_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              rden_nxt;
  logic [DATA_W-1:0] sample_nxt;
  logic [TRK_W-1:0]  track_nxt;
  logic              done_nxt;

  logic [ADDR_W-1:0] cur_start, cur_end, sel_start;
  logic [DATA_W-1:0] rom_shaped;
  logic              sel_valid;

  assign cur_start = START_ADDRS[cur_track*ADDR_W +: ADDR_W];
  assign cur_end   = END_ADDRS[cur_track*ADDR_W +: ADDR_W];
  assign sel_start = START_ADDRS[track_sel*ADDR_W +: ADDR_W];
  assign sel_valid = 32'(track_sel) < NUM_TRACKS;
  assign busy      = (state != S_IDLE);

`ifdef VOLUME_ATTEN_EN
  assign rom_shaped = $signed(rom_q) >>> vol;
`else
  assign rom_shaped = rom_q;
`endif

  always_ff @(posedge DAC_LR_CLK) begin
    if (!reset) begin
      state      <= S_IDLE;
      loop_q     <= 1'b0;
      rom_addr   <= '0;
      rom_rden   <= 1'b0;
      sample_out <= '0;
      cur_track  <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      loop_q     <= loop_nxt;
      rom_addr   <= addr_nxt;
      rom_rden   <= rden_nxt;
      sample_out <= sample_nxt;
      cur_track  <= track_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    loop_nxt   = loop_q;
    addr_nxt   = rom_addr;
    rden_nxt   = rom_rden;
    sample_nxt = sample_out;
    track_nxt  = cur_track;
    done_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        sample_nxt = '0;
        rden_nxt   = 1'b0;
      end
      S_START: begin
        sample_nxt = '0;
        if (cur_end == cur_start) begin
          rden_nxt  = 1'b0;
          state_nxt = S_DRAIN;
        end else begin
          addr_nxt  = rom_addr + 1'b1;
          state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        // The in-flight sample is still taken on pause entry so it is not lost.
        sample_nxt = rom_shaped;
        if (pause) begin
          rden_nxt  = 1'b0;
          state_nxt = S_PAUSE;
        end else if (rom_addr == cur_end) begin
          if (loop_q) begin
            addr_nxt = cur_start;
          end else begin
            rden_nxt  = 1'b0;
            state_nxt = S_DRAIN;
          end
        end else begin
          addr_nxt = rom_addr + 1'b1;
        end
      end
      S_PAUSE: begin
        if (!pause) begin
          rden_nxt  = 1'b1;
          state_nxt = S_PLAY;
        end
      end
      S_DRAIN: begin
        sample_nxt = rom_shaped;
        done_nxt   = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (play_req && sel_valid) begin
      state_nxt  = S_START;
      loop_nxt   = loop_mode;
      track_nxt  = track_sel;
      addr_nxt   = sel_start;
      rden_nxt   = 1'b1;
      sample_nxt = '0;
      done_nxt   = 1'b0;
    end

    // Stop outranks a simultaneous play; in IDLE it is a no-op.
    if (stop_req && busy) begin
      state_nxt  = S_IDLE;
      loop_nxt   = loop_q;
      track_nxt  = cur_track;
      addr_nxt   = rom_addr;
      rden_nxt   = 1'b0;
      sample_nxt = '0;
      done_nxt   = 1'b1;
    end
  end

endmodule
